// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant is held for a whole packet, or until MAX_BURST beats have been written.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int SCW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_din,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic [SCW-1:0]     stall_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [2:0]     grant_r;
  logic [2:0]     last_grant_r;
  logic [2:0]     pick_s;
  logic           found_s;
  int             best_dist_s;
  logic [7:0]     beat_cnt_r;
  logic [SCW-1:0] stall_r;
  logic           granted_s;
  logic           sel_valid_s;
  logic           sel_last_s;
  logic [DW-1:0]  sel_data_s;
  logic           accept_s;
  logic           release_s;

  // Round-robin pick: the valid requester closest after the last released grant wins.
  always_comb begin
    pick_s      = last_grant_r;
    best_dist_s = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      int d;
      d = (i + NREQ - int'(last_grant_r) - 1) % NREQ;
      if (req_valid[i] && (d < best_dist_s)) begin
        best_dist_s = d;
        pick_s      = 3'(i);
      end else begin
        best_dist_s = best_dist_s;
        pick_s      = pick_s;
      end
    end
    found_s = (best_dist_s < NREQ);
  end

  // Steer the granted requester's beat onto the FIFO side.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = sel_valid_s | (req_valid[i] & (grant_r == 3'(i)));
      sel_last_s  = sel_last_s  | (req_last[i]  & (grant_r == 3'(i)));
      sel_data_s  = sel_data_s  | (req_data[i*DW +: DW] & {DW{grant_r == 3'(i)}});
    end
  end

  // Handshake outputs; reset gates them so nothing is written in the reset cycle.
  always_comb begin
    granted_s = (state_r == GRANT) && !rst;
    accept_s  = granted_s && sel_valid_s && !fifo_full;
    release_s = accept_s && (sel_last_s || (beat_cnt_r == 8'(MAX_BURST - 1)));
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = granted_s && !fifo_full && (grant_r == 3'(i));
    end
    fifo_wr  = accept_s;
    fifo_din = sel_data_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = found_s ? GRANT : IDLE;
      GRANT:   state_nxt_s = release_s ? IDLE : GRANT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant holder, beat counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 3'd0;
      last_grant_r <= 3'(NREQ - 1);
      beat_cnt_r   <= 8'd0;
      stall_r      <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r    <= pick_s;
            beat_cnt_r <= 8'd0;
          end
        end
        GRANT: begin
          if (accept_s) begin
            if (release_s) begin
              last_grant_r <= grant_r;
              beat_cnt_r   <= 8'd0;
            end else begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
          end else if (fifo_full && sel_valid_s && (stall_r != {SCW{1'b1}})) begin
            stall_r <= stall_r + SCW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy      = (state_r == GRANT);
  assign grant_id  = grant_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues drive the DUT and a
// rule-based reference model predicts grants, writes and stall counts each cycle.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 4;
  localparam int SCW  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic [2:0]         grant_id;
  logic               busy;
  logic [SCW-1:0]     stall_cnt;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB), .SCW(SCW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .grant_id(grant_id),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who holds the grant, how many beats it has sent, stall cycles
  bit m_busy;
  int m_gid, m_last, m_beats, m_stall;

  // producer packet queues: bit DW is the last flag
  logic [DW:0]     pmem [NREQ][64];
  int              phead [NREQ];
  int              ptail [NREQ];
  logic [NREQ-1:0] acc_vec;
  logic [NREQ-1:0] hold_mask;

  logic [DW-1:0] wr_log[$];
  int            gnt_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first valid requester in cyclic order after 'last'
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] e_ready;
    logic            e_wr;
    int              p;
    #1;
    e_ready = '0;
    e_wr    = 1'b0;
    if (m_busy && !rst) begin
      e_ready[m_gid] = !fifo_full;
      e_wr           = req_valid[m_gid] && !fifo_full;
    end
    chk("req_ready", req_ready, e_ready);
    chk("ready_onehot0", $onehot0(req_ready), 1'b1);
    chk("fifo_wr", fifo_wr, e_wr);
    if (e_wr) begin
      chk("fifo_din", fifo_din, req_data[m_gid*DW +: DW]);
      wr_log.push_back(fifo_din);
    end
    acc_vec = req_valid & req_ready;
    if (rst) begin
      m_busy = 1'b0; m_gid = 0; m_last = NREQ - 1; m_beats = 0; m_stall = 0;
    end else if (!m_busy) begin
      p = rr_pick(m_last, req_valid);
      if (p >= 0) begin
        m_busy = 1'b1; m_gid = p; m_beats = 0;
        gnt_log.push_back(p);
      end
    end else if (e_wr) begin
      m_beats++;
      if (req_last[m_gid] || m_beats == MB) begin
        m_last = m_gid; m_busy = 1'b0; m_beats = 0;
      end
    end else if (fifo_full && req_valid[m_gid] && m_stall < (2**SCW - 1)) begin
      m_stall++;
    end
    @(posedge clk);
    #1;
    chk("busy", busy, m_busy);
    if (m_busy) chk("grant_id", grant_id, 3'(m_gid));
    chk("stall_cnt", stall_cnt, SCW'(m_stall));
  endtask

  // advance producer queues, drive one cycle of stimulus, then check it
  task automatic tick(input bit full_v, input bit gaps);
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) phead[i]++;
      if (phead[i] >= ptail[i] || hold_mask[i]) begin
        req_valid[i] = 1'b0;
      end else if (req_valid[i] && !acc_vec[i]) begin
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (phead[i] < ptail[i]) begin
        req_data[i*DW +: DW] = pmem[i][phead[i]][DW-1:0];
        req_last[i]          = pmem[i][phead[i]][DW];
      end else begin
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    fifo_full = full_v;
    cycle();
  endtask

  task automatic load(input int i, input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++) begin
      pmem[i][ptail[i]] = {(b == n - 1), base + DW'(b)};
      ptail[i]++;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0; ptail[i] = 0;
    end
    acc_vec = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    wr_log.delete();
    gnt_log.delete();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++) begin
      if (phead[i] + int'(acc_vec[i]) < ptail[i]) return 1'b0;
    end
    return !m_busy;
  endfunction

  task automatic drain(input string tag);
    for (int c = 0; c < 300 && !all_done(); c++) tick(1'b0, 1'b0);
    chk(tag, all_done(), 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    hold_mask = '0;
    m_busy = 1'b0; m_gid = 0; m_last = NREQ - 1; m_beats = 0; m_stall = 0;
    clear_q();
    do_reset();
    tick(1'b0, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stall", stall_cnt, 16'd0);
    chk("reset_wr", fifo_wr, 1'b0);

    // single requester 1, three beats
    load(1, 3, 32'hA1);
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b0);
    chk("t1_nwr", wr_log.size(), 3);
    chk("t1_d0", wr_log[0], 32'hA1);
    chk("t1_d1", wr_log[1], 32'hA2);
    chk("t1_d2", wr_log[2], 32'hA3);
    chk("t1_gnt", gnt_log[0], 1);
    chk("t1_stall", stall_cnt, 16'd0);

    // all four requesters, single-beat packets
    do_reset(); clear_q();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 1, 32'h100 + 32'(i)); load(i, 1, 32'h110 + 32'(i));
    end
    for (int c = 0; c < 20; c++) tick(1'b0, 1'b0);
    chk("t2_ngnt", gnt_log.size(), 8);
    chk("t2_g0", gnt_log[0], 0);
    chk("t2_g1", gnt_log[1], 1);
    chk("t2_g2", gnt_log[2], 2);
    chk("t2_g3", gnt_log[3], 3);
    chk("t2_g4", gnt_log[4], 0);

    // 6-beat packet from 2 is split by MAX_BURST, requester 3 goes in between
    do_reset(); clear_q();
    load(2, 6, 32'h200); load(3, 2, 32'h300);
    for (int c = 0; c < 14; c++) tick(1'b0, 1'b0);
    chk("t3_ngnt", gnt_log.size(), 3);
    chk("t3_g0", gnt_log[0], 2);
    chk("t3_g1", gnt_log[1], 3);
    chk("t3_g2", gnt_log[2], 2);
    chk("t3_nwr", wr_log.size(), 8);
    chk("t3_d3", wr_log[3], 32'h203);
    chk("t3_d4", wr_log[4], 32'h300);
    chk("t3_d6", wr_log[6], 32'h204);

    // fifo_full for five granted cycles
    do_reset(); clear_q();
    load(0, 2, 32'h10);
    for (int c = 0; c < 6; c++) tick(1'b1, 1'b0);
    chk("t4_stall", stall_cnt, 16'd5);
    chk("t4_nowr", wr_log.size(), 0);
    tick(1'b0, 1'b0);
    chk("t4_wr_after", wr_log.size(), 1);
    tick(1'b0, 1'b0);
    chk("t4_d1", wr_log[1], 32'h11);
    chk("t4_stall_hold", stall_cnt, 16'd5);

    // granted requester drops valid mid-packet
    do_reset(); clear_q();
    load(1, 4, 32'h40); load(2, 1, 32'h50); load(3, 1, 32'h60);
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
    hold_mask = 4'b0010;
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
    chk("t5_hold_gnt", grant_id, 3'd1);
    chk("t5_hold_busy", busy, 1'b1);
    chk("t5_hold_nwr", wr_log.size(), 2);
    hold_mask = '0;
    for (int c = 0; c < 12; c++) tick(1'b0, 1'b0);
    chk("t5_ngnt", gnt_log.size(), 3);
    chk("t5_g1", gnt_log[1], 2);
    chk("t5_d3", wr_log[3], 32'h43);
    chk("t5_stall", stall_cnt, 16'd0);

    // reset on the second beat of a burst
    do_reset(); clear_q();
    load(2, 4, 32'h60);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_stall", stall_cnt, 16'd0);
    chk("t6_nwr", wr_log.size(), 1);
    gnt_log.delete();
    load(0, 1, 32'h70);
    tick(1'b0, 1'b0);
    chk("t6_first", gnt_log[0], 0);
    drain("t6_drain");

    // randomized traffic with gaps and backpressure
    for (int r = 0; r < 6; r++) begin
      do_reset(); clear_q();
      for (int i = 0; i < NREQ; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) load(i, $urandom_range(1, 6), $urandom());
      end
      for (int c = 0; c < 120; c++) tick($urandom_range(0, 3) == 0, 1'b1);
      drain("rand_drain");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
